// File: rtl/fir_pkg.sv
// Shared constants, feeder state encoding and configuration helpers for the
// fir_lane pcm-side feeder.
package fir_pkg;

    localparam int FIR_DATA_W = 16;
    localparam int FIR_ADDR_W = 9;
    localparam int FIR_SEP_W  = 8;
    localparam int CFG_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } feed_state_e;

    // A zero configuration field behaves as one.
    function automatic logic [CFG_W-1:0] cfg_clamp(input logic [CFG_W-1:0] v);
        return (v == '0) ? CFG_W'(1) : v;
    endfunction

endpackage

// File: rtl/fir_feed_pacer.sv
// Write pacer: accepts one sample, writes it into the fir_lane ring, then holds
// off further samples until the configured write spacing has elapsed.
module fir_feed_pacer
    import fir_pkg::*;
#(
    parameter int ADDR_W = FIR_ADDR_W,
    parameter int DATA_W = FIR_DATA_W,
    parameter int SEP_W  = FIR_SEP_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [SEP_W-1:0]  sep_i,
    output logic              in_ready_o,
    output logic              wr_o,
    output logic [DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0] addr_o
);

    feed_state_e       state_q, state_d;
    logic [SEP_W-1:0]  gap_q, gap_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              restart;
    logic              accept;

    assign restart = rst_i | flush_i;
    assign accept  = in_ready_o & in_valid_i;

    always_ff @(posedge clk_i) begin
        if (restart) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // WRITE plus (sep-2) GAP cycles plus the IDLE accept cycle give a spacing of max(sep,2).
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d  = in_data_i;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr_d = addr_q + ADDR_W'(1);
                if (sep_i > SEP_W'(2)) begin
                    gap_d   = sep_i - SEP_W'(2);
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_q <= SEP_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - SEP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A restart request also masks ready so a coincident sample is never taken.
    always_comb begin
        in_ready_o = 1'b0;
        wr_o       = 1'b0;
        case (state_q)
            ST_IDLE:  in_ready_o = ~restart;
            ST_WRITE: wr_o = 1'b1;
            default:  ;
        endcase
    end

    assign data_o = data_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/fir_lane_feeder.sv
// pcm-side front end for fir_lane: paced ring writes, decimated fir_start
// generation and warm-up-gated capture of the filtered result.
module fir_lane_feeder
    import fir_pkg::*;
#(
    parameter int ADDR_W = FIR_ADDR_W,
    parameter int DATA_W = FIR_DATA_W,
    parameter int SEP_W  = FIR_SEP_W
) (
    input  logic              pcm_clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              flush,
    input  logic [SEP_W-1:0]  cfg_sep,
    input  logic [3:0]        cfg_downsample,
    input  logic [7:0]        cfg_tap_len,
    output logic              pcm_in_wr,
    output logic [DATA_W-1:0] pcm_in,
    output logic [ADDR_W-1:0] pcm_in_address,
    output logic              fir_start,
    input  logic [DATA_W-1:0] pcm_out,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              restart;
    logic              wr;
    logic [SEP_W-1:0]  sep_q;
    logic [3:0]        ds_q;
    logic [7:0]        tap_q;
    logic [3:0]        phase_q, phase_d;
    logic [7:0]        warm_q, warm_d;
    logic              pending_q, pending_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [4:0]        phase_inc;
    logic [8:0]        warm_inc;
    logic              start;
    logic              primed;

    assign restart = rst | flush;

    fir_feed_pacer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SEP_W  (SEP_W)
    ) u_pacer (
        .clk_i      (pcm_clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_data_i  (in_data),
        .sep_i      (sep_q),
        .in_ready_o (in_ready),
        .wr_o       (wr),
        .data_o     (pcm_in),
        .addr_o     (pcm_in_address)
    );

    // Configuration is only sampled on a restart so live cfg_* edits are ignored.
    always_ff @(posedge pcm_clk) begin
        if (restart) begin
            sep_q <= SEP_W'(cfg_clamp(CFG_W'(cfg_sep)));
            ds_q  <= 4'(cfg_clamp(CFG_W'(cfg_downsample)));
            tap_q <= 8'(cfg_clamp(CFG_W'(cfg_tap_len)));
        end
    end

    assign phase_inc = {1'b0, phase_q} + 5'd1;
    assign warm_inc  = {1'b0, warm_q} + 9'd1;
    assign start     = wr & (phase_inc == {1'b0, ds_q});
    assign primed    = warm_inc >= {1'b0, tap_q};

    // pcm_out still holds the previous start's result until this start is taken.
    always_comb begin
        phase_d     = phase_q;
        warm_d      = warm_q;
        pending_d   = pending_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        if (wr) begin
            phase_d = start ? 4'd0 : phase_inc[3:0];
            warm_d  = primed ? tap_q : warm_inc[7:0];
        end
        if (start) begin
            pending_d = primed;
            if (pending_q) begin
                out_valid_d = 1'b1;
                out_data_d  = pcm_out;
            end
        end
    end

    always_ff @(posedge pcm_clk) begin
        if (restart) begin
            phase_q     <= '0;
            warm_q      <= '0;
            pending_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            phase_q     <= phase_d;
            warm_q      <= warm_d;
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign pcm_in_wr = wr;
    assign fir_start = start;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
